// File: rtl/sseg_pkg.sv
// Shared constants for the scanned seven-segment driver.
// Contains the segment bit positions, the blank pattern and the hex glyph table.
package sseg_pkg;

  // Bit positions inside the 8-bit segment word {dp,a,b,c,d,e,f,g}
  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // {a..g} glyphs, entry k is the pattern for hex digit k (listed F down to 0)
  localparam logic [15:0][6:0] SEG_PATTERN = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // D
    7'b1001110,  // C
    7'b0011111,  // B
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to {a..g} glyph lookup.
module hex_seg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup into the shared glyph ROM
  always_comb begin
    seg = SEG_PATTERN[hex];
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered display
// data, per-digit dp/blanking, leading-zero blanking and PWM brightness.
// Outputs are registered; the output slot of each digit ends with one dark
// cycle so the anode change never overlaps the previous digit's segments.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int DUTY_W         = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lzb_en,
  input  logic [DUTY_W-1:0]     duty,
  output logic [7:0]            sseg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  localparam logic [7:0]          SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DUTY_W-1:0] pwm_cnt;

  logic [N_DIGITS-1:0][3:0] pend_hex;
  logic [N_DIGITS-1:0]      pend_dp;
  logic [N_DIGITS-1:0]      pend_blank;
  logic [N_DIGITS-1:0][3:0] com_hex;
  logic [N_DIGITS-1:0]      com_dp;
  logic [N_DIGITS-1:0]      com_blank;

  logic                slot_last;
  logic                wrap;
  logic [N_DIGITS-1:0] lzb_mask;
  logic                lz_seen;
  logic [3:0]          cur_hex;
  logic [6:0]          cur_glyph;
  logic                lit;
  logic [7:0]          sseg_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  logic [7:0]          sseg_q;
  logic [N_DIGITS-1:0] an_q;
  logic                tick_q;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign wrap      = slot_last && (idx == IDX_LAST);

  // Slot timer and digit index; the index steps on the last cycle of a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Free-running brightness counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Pending buffer: the most recent load wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
    end else if (load) begin
      pend_hex   <= hex_in;
      pend_dp    <= dp_in;
      pend_blank <= blank_in;
    end
  end

  // Committed buffer only changes at frame wrap, so a frame never mixes two loads;
  // it takes the pending value from before any load in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      com_hex   <= '0;
      com_dp    <= '0;
      com_blank <= '1;
    end else if (wrap) begin
      com_hex   <= pend_hex;
      com_dp    <= pend_dp;
      com_blank <= pend_blank;
    end
  end

  // Leading-zero mask: walk down from the MSD until something visible appears
  always_comb begin
    lzb_mask = '0;
    lz_seen  = 1'b0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if ((com_hex[k] != 4'h0) || com_dp[k]) begin
        lz_seen = 1'b1;
      end
      lzb_mask[k] = lzb_en & ~lz_seen;
    end
  end

  assign cur_hex = com_hex[idx];

  hex_seg_decode u_decode (
    .hex (cur_hex),
    .seg (cur_glyph)
  );

  // Next output word for the current digit; the final slot cycle is the ghosting guard
  always_comb begin
    lit = ~com_blank[idx] & ~lzb_mask[idx] & (pwm_cnt < duty) & ~slot_last;
    sseg_nxt = SEG_OFF;
    an_nxt   = '0;
    if (lit) begin
      sseg_nxt[SEG_DP]    = com_dp[idx];
      sseg_nxt[SEG_A:SEG_G] = cur_glyph;
      an_nxt              = N_DIGITS'(1) << idx;
    end
  end

  // Output registers, frame_tick follows the wrap cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sseg_q <= SEG_OFF;
      an_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      sseg_q <= sseg_nxt;
      an_q   <= an_nxt;
      tick_q <= wrap;
    end
  end

  assign sseg       = sseg_q ^ SEG_INV;
  assign an         = an_q ^ AN_INV;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two instances (plain and inverted pin polarity)
// driven identically and checked every cycle against a frame-arithmetic model,
// plus hand-computed glyph and timing expectations.
module tb_sseg_scan_driver;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int DW = 2;
  localparam int FR = N * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [1:0]  duty = '0;

  logic [7:0] sseg0, sseg1;
  logic [3:0] an0, an1;
  logic       tick0, tick1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(S), .DUTY_W(DW), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut_pos (
    .clk(clk), .rst_n(rst_n), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .lzb_en(lzb_en), .duty(duty),
    .sseg(sseg0), .an(an0), .frame_tick(tick0)
  );

  sseg_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(S), .DUTY_W(DW), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .lzb_en(lzb_en), .duty(duty),
    .sseg(sseg1), .an(an1), .frame_tick(tick1)
  );

  // ---------------- behavioural model ----------------
  int          n;
  logic [15:0] p_hex, c_hex;
  logic [3:0]  p_dp, c_dp, p_blank, c_blank;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_tick;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic bit lz_dark(input int k, input bit en, input logic [15:0] h, input logic [3:0] d);
    if (!en || k == 0) return 1'b0;
    for (int j = k; j < N; j++) begin
      if (4'(h >> (4 * j)) != 4'h0 || d[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // n counts clock edges since reset release; slot, digit and pwm phase follow from it
  always @(posedge clk or negedge rst_n) begin
    int  slot, idx, pwm;
    bit  dark, wrap;
    if (!rst_n) begin
      n = 0;
      p_hex = '0; p_dp = '0; p_blank = '1;
      c_hex = '0; c_dp = '0; c_blank = '1;
      exp_seg = '0; exp_an = '0; exp_tick = 1'b0;
    end else begin
      slot = n % S;
      idx  = (n / S) % N;
      pwm  = n % (1 << DW);
      wrap = (slot == S - 1) && (idx == N - 1);
      dark = c_blank[idx] || (slot == S - 1) || (pwm >= int'(duty)) ||
             lz_dark(idx, lzb_en, c_hex, c_dp);
      exp_seg  = dark ? 8'h00 : {c_dp[idx], glyph(4'(c_hex >> (4 * idx)))};
      exp_an   = dark ? 4'b0000 : 4'(1 << idx);
      exp_tick = wrap;
      if (wrap) begin
        c_hex = p_hex; c_dp = p_dp; c_blank = p_blank;
      end
      if (load) begin
        p_hex = hex_in; p_dp = dp_in; p_blank = blank_in;
      end
      n = n + 1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    tests++;
    if (sseg0 !== exp_seg || an0 !== exp_an || tick0 !== exp_tick ||
        sseg1 !== ~exp_seg || an1 !== ~exp_an || tick1 !== exp_tick) begin
      failed++;
      $display("FAIL pins t=%0t got pos sseg=%h an=%b tick=%b inv sseg=%h an=%b tick=%b, required sseg=%h an=%b tick=%b (inv %h %b)",
               $time, sseg0, an0, tick0, sseg1, an1, tick1, exp_seg, exp_an, exp_tick, ~exp_seg, ~exp_an);
    end
    tests++;
    if ($countones(an0) > 1) begin
      failed++;
      $display("FAIL onehot t=%0t an=%b, required at most one bit set", $time, an0);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic load_once(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    hex_in = h; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge clk);
      if (tick0) seen = 1'b1;
    end
    if (!seen) check({name, "_tick_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_digit_check(input string name, input int k, input logic [7:0] req);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge clk);
      if (an0 == 4'(1 << k)) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    else check(name, {24'd0, sseg0}, {24'd0, req});
  endtask

  task automatic count_lit(input int cycles, output int lit, output int hi);
    lit = 0; hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (an0 != 4'b0000) lit++;
      if (an0[3] || an0[2]) hi++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lit, hi, gap;
    bit seen;

    // 1: reset with random inputs
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hex_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
      lzb_en = 1'($urandom); duty = 2'($urandom); load = 1'($urandom);
      @(negedge clk);
    end
    check("rst_sseg", {24'd0, sseg0}, 32'h00);
    check("rst_an", {28'd0, an0}, 32'h0);
    check("rst_tick", {31'd0, tick0}, 32'd0);
    load = 1'b0; lzb_en = 1'b0; duty = 2'd3;
    hex_in = '0; dp_in = '0; blank_in = '0;
    rst_n = 1'b1;

    // 2: load 12AF, duty 3 (load during the first, dark, frame)
    load_once(16'h12AF, 4'b0000, 4'b0000);
    count_lit(FR - 2, lit, hi);
    check("first_frame_dark", lit, 0);
    wait_tick("c2");
    wait_digit_check("c2_digit0_F", 0, 8'h47);
    wait_digit_check("c2_digit3_1", 3, 8'h30);
    wait_tick("c2b");
    count_lit(FR, lit, hi);
    check("c2_lit_per_frame", lit, 12);
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (tick0) seen = 1'b1;
    end
    wait_tick("c2c");
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (tick0) seen = 1'b1;
    end
    check("c2_tick_period", gap, FR);

    // 3: leading-zero blanking
    lzb_en = 1'b1;
    load_once(16'h0050, 4'b0000, 4'b0000);
    wait_tick("c3"); wait_tick("c3b");
    count_lit(FR, lit, hi);
    check("c3_upper_dark", hi, 0);
    check("c3_lit", lit, 6);
    wait_digit_check("c3_digit1_5", 1, 8'h5B);
    wait_digit_check("c3_digit0_0", 0, 8'h7E);
    load_once(16'h0050, 4'b1000, 4'b0000);
    wait_tick("c3c"); wait_tick("c3d");
    wait_digit_check("c3_digit3_dp0", 3, 8'hFE);

    // 4: load in the wrap cycle, second load mid-frame
    lzb_en = 1'b0;
    for (int i = 0; i < 2 * FR && (n % FR) != FR - 1; i++) @(negedge clk);
    check("c4_align", n % FR, FR - 1);
    load_once(16'h3333, 4'b0000, 4'b0000);
    wait_digit_check("c4_old_frame", 0, 8'h7E);
    load_once(16'h7777, 4'b0000, 4'b0000);
    wait_tick("c4");
    wait_digit_check("c4_new_frame", 0, 8'h70);
    wait_digit_check("c4_new_frame_d3", 3, 8'h70);

    // 5: duty extremes
    duty = 2'd0;
    count_lit(3 * FR, lit, hi);
    check("c5_duty0", lit, 0);
    duty = 2'd1;
    @(negedge clk);
    count_lit(FR, lit, hi);
    check("c5_duty1", lit, 4);

    // 6: inverted pins, async reset mid-slot
    duty = 2'd3;
    load_once(16'h12AF, 4'b0000, 4'b0000);
    wait_tick("c6"); wait_tick("c6b");
    wait_digit_check("c6_pos_digit0", 0, 8'h47);
    check("c6_inv_sseg", {24'd0, sseg1}, {24'd0, ~8'h47});
    check("c6_inv_an", {28'd0, an1}, 32'hE);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("c6_rst_inv_sseg", {24'd0, sseg1}, 32'hFF);
    check("c6_rst_inv_an", {28'd0, an1}, 32'hF);
    check("c6_rst_pos_sseg", {24'd0, sseg0}, 32'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    count_lit(FR - 1, lit, hi);
    check("c6_restart_dark", lit, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 5) == 0);
      hex_in = 16'($urandom);
      dp_in = 4'($urandom & $urandom);
      blank_in = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) begin
        hex_in = 16'($urandom_range(0, 255));
        lzb_en = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) duty = 2'($urandom);
      if (i == 300) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    load = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
